// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcodes, format encoding and pipeline entry type shared by the immediate generator
package imm_gen_pkg;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam int MAX_XLEN  = 64;
    localparam int MAX_TAG_W = 64;
    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR_UIMM
    } fmt_t;
    typedef struct packed {
        logic [MAX_XLEN-1:0]  imm;
        fmt_t                 fmt;
        logic                 illegal;
        logic [MAX_TAG_W-1:0] tag;
    } entry_t;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate/format decode; IMM_GEN_CSR_UIMM_EN enables CSR uimm extraction
module imm_extract import imm_gen_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
`ifdef IMM_GEN_CSR_UIMM_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif
    logic [6:0] op;
    fmt_t f;
    logic signed [31:0] v;
    always_comb begin
        op = instr[6:0];
        f = (op == LOAD || op == OP_IMM || op == JALR || (XLEN == 64 && op == OP_IMM_32)) ? FMT_I :
            op == STORE ? FMT_S :
            op == BRANCH ? FMT_B :
            (op == LUI || op == AUIPC) ? FMT_U :
            op == JAL ? FMT_J :
            (CSR_EN && op == SYSTEM && instr[14]) ? FMT_CSR_UIMM : FMT_NONE;
        illegal = f == FMT_NONE && !(CSR_EN && op == SYSTEM);
        v = f == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
            f == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            f == FMT_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            f == FMT_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            f == FMT_U ? {instr[31:12], 12'b0} : 32'sd0;
        imm = f == FMT_CSR_UIMM ? XLEN'(instr[19:15]) : XLEN'(v);
        fmt = f;
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with skid buffer, flush and illegal counter (IMM_GEN_CSR_UIMM_EN)
module imm_gen_pipe import imm_gen_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [CNT_W-1:0] ill_cnt_o
);
    logic [XLEN-1:0] x_imm;
    logic [2:0] x_fmt;
    logic x_ill, out_v, skid_v, acc, load, unused_hi;
    entry_t out_q, skid_q, in_e;
    imm_extract #(.XLEN(XLEN)) u_ext (.instr(instr_i), .imm(x_imm), .fmt(x_fmt), .illegal(x_ill));
    always_comb begin
        in_e = '{imm: MAX_XLEN'(x_imm), fmt: fmt_t'(x_fmt), illegal: x_ill, tag: MAX_TAG_W'(tag_i)};
        acc  = in_valid_i && in_ready_o;
        load = !out_v || out_ready_i;
    end
    assign in_ready_o  = !skid_v && !flush_i;
    assign out_valid_o = out_v;
    assign imm_o       = out_q.imm[XLEN-1:0];
    assign fmt_o       = out_q.fmt;
    assign illegal_o   = out_q.illegal;
    assign tag_o       = out_q.tag[TAG_W-1:0];
    assign unused_hi   = ^{out_q.imm, out_q.tag};
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_v     <= 1'b0;
            skid_v    <= 1'b0;
            ill_cnt_o <= '0;
        end else begin
            if (acc && x_ill && ill_cnt_o != '1) ill_cnt_o <= ill_cnt_o + CNT_W'(1);
            if (flush_i) begin
                out_v  <= 1'b0;
                skid_v <= 1'b0;
            end else if (load) begin
                out_v  <= skid_v || acc;
                skid_v <= 1'b0;
                if (skid_v) out_q <= skid_q;
                else if (acc) out_q <= in_e;
            end else if (acc) begin
                skid_v <= 1'b1;
                skid_q <= in_e;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: vector table, handshake corner sequences and random traffic against a reference model
module tb_imm_gen_pipe;
    logic clk = 0, rst = 1, flush_i = 0, in_valid_i = 0, out_ready_i = 0;
    logic [31:0] instr_i = 0, tag_i = 0;
    logic ir32, ov32, ill32, ir64, ov64, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [2:0] fmt32, fmt64;
    logic [1:0] cnt32;
    logic [15:0] cnt64;
    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) u32 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(ir32),
        .instr_i(instr_i), .tag_i(tag_i), .out_valid_o(ov32), .out_ready_i(out_ready_i),
        .imm_o(imm32), .fmt_o(fmt32), .illegal_o(ill32), .tag_o(tag32), .ill_cnt_o(cnt32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) u64 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(ir64),
        .instr_i(instr_i), .tag_i(tag_i), .out_valid_o(ov64), .out_ready_i(out_ready_i),
        .imm_o(imm64), .fmt_o(fmt64), .illegal_o(ill64), .tag_o(tag64), .ill_cnt_o(cnt64));

    typedef struct {logic [63:0] imm; logic [2:0] fmt; logic ill;} exp_t;
    typedef struct {logic [31:0] instr; logic [31:0] tag;} pend_t;
    typedef struct {logic [31:0] instr; logic [63:0] imm32; logic [2:0] f32; logic il32;
                    logic [63:0] imm64; logic [2:0] f64; logic il64;} vec_t;

    int n_chk = 0, n_fail = 0, del_cnt = 0;
    logic ov[2], ir[2], il[2];
    logic [63:0] im[2];
    logic [2:0] fm[2];
    logic [31:0] tg[2];
    logic [15:0] ct[2];
    always_comb begin
        ov[0] = ov32; ir[0] = ir32; il[0] = ill32; im[0] = 64'(imm32); fm[0] = fmt32; tg[0] = tag32; ct[0] = 16'(cnt32);
        ov[1] = ov64; ir[1] = ir64; il[1] = ill64; im[1] = imm64; fm[1] = fmt64; tg[1] = tag64; ct[1] = cnt64;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input bit x64);
        logic signed [63:0] v;
        exp_t e;
        v = 0;
        e.fmt = 0;
        e.ill = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin e.fmt = 1; v = $signed(ins[31:20]); end
            7'h1B: if (x64) begin e.fmt = 1; v = $signed(ins[31:20]); end else e.ill = 1;
            7'h23: begin e.fmt = 2; v = $signed({ins[31:25], ins[11:7]}); end
            7'h63: begin e.fmt = 3; v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); end
            7'h6F: begin e.fmt = 5; v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); end
            7'h37, 7'h17: begin e.fmt = 4; v = $signed({ins[31:12], 12'h000}); end
`ifdef IMM_GEN_CSR_UIMM_EN
            7'h73: if (ins[14]) begin e.fmt = 6; v = 64'(ins[19:15]); end
`else
            7'h73: e.ill = 1;
`endif
            default: e.ill = 1;
        endcase
        e.imm = x64 ? v : {32'h0, v[31:0]};
        return e;
    endfunction

    pend_t q[2][$];
    int cm[2];
    bit hv[2];
    logic [63:0] h_im[2];
    logic [2:0] h_fm[2];
    logic h_il[2];
    logic [31:0] h_tg[2];

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                cm[d] = 0;
                hv[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                string s;
                exp_t e;
                pend_t p;
                s = d ? "x64" : "x32";
                chk({s, " ill_cnt"}, 64'(ct[d]), 64'(cm[d]));
                if (hv[d]) begin
                    chk({s, " hold_valid"}, 64'(ov[d]), 64'(1));
                    chk({s, " hold_imm"}, im[d], h_im[d]);
                    chk({s, " hold_fmt"}, 64'(fm[d]), 64'(h_fm[d]));
                    chk({s, " hold_illegal"}, 64'(il[d]), 64'(h_il[d]));
                    chk({s, " hold_tag"}, 64'(tg[d]), 64'(h_tg[d]));
                end
                hv[d] = ov[d] && !out_ready_i && !flush_i;
                h_im[d] = im[d]; h_fm[d] = fm[d]; h_il[d] = il[d]; h_tg[d] = tg[d];
                if (flush_i) chk({s, " flush_in_ready"}, 64'(ir[d]), 64'(0));
                if (ov[d] && out_ready_i && !flush_i) begin
                    if (q[d].size() == 0) chk({s, " spurious_out"}, 64'(ov[d]), 64'(0));
                    else begin
                        p = q[d].pop_front();
                        e = model(p.instr, d == 1);
                        chk({s, " out_imm"}, im[d], e.imm);
                        chk({s, " out_fmt"}, 64'(fm[d]), 64'(e.fmt));
                        chk({s, " out_illegal"}, 64'(il[d]), 64'(e.ill));
                        chk({s, " out_tag"}, 64'(tg[d]), 64'(p.tag));
                        if (d == 0) del_cnt++;
                    end
                end
                if (flush_i) q[d].delete();
                else if (in_valid_i && ir[d]) begin
                    p.instr = instr_i;
                    p.tag = tag_i;
                    q[d].push_back(p);
                    e = model(instr_i, d == 1);
                    if (e.ill && cm[d] < (d ? 65535 : 3)) cm[d]++;
                end
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    task automatic add(input logic [31:0] ins, input logic [63:0] i32, input logic [2:0] f32, input logic l32,
                       input logic [63:0] i64, input logic [2:0] f64, input logic l64);
        vec_t v;
        v.instr = ins; v.imm32 = i32; v.f32 = f32; v.il32 = l32; v.imm64 = i64; v.f64 = f64; v.il64 = l64;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] st[4];
        logic [6:0] ops[12];
        int k;
        int base;
        logic a;
        add(32'hFFF00093, 64'hFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0);
        add(32'hFE112E23, 64'hFFFFFFFC, 2, 0, 64'hFFFFFFFFFFFFFFFC, 2, 0);
        add(32'h800002B7, 64'h80000000, 4, 0, 64'hFFFFFFFF80000000, 4, 0);
        add(32'h0010809B, 64'h0, 0, 1, 64'h1, 1, 0);
        add(32'h00000000, 64'h0, 0, 1, 64'h0, 0, 1);
        add(32'hFE000EE3, 64'hFFFFFFFC, 3, 0, 64'hFFFFFFFFFFFFFFFC, 3, 0);
        add(32'h0080006F, 64'h8, 5, 0, 64'h8, 5, 0);
        add(32'h00001517, 64'h1000, 4, 0, 64'h1000, 4, 0);
        add(32'h80002083, 64'hFFFFF800, 1, 0, 64'hFFFFFFFFFFFFF800, 1, 0);
        add(32'h000080E7, 64'h0, 1, 0, 64'h0, 1, 0);
        add(32'h0000007F, 64'h0, 0, 1, 64'h0, 0, 1);
`ifdef IMM_GEN_CSR_UIMM_EN
        add(32'h34015073, 64'h2, 6, 0, 64'h2, 6, 0);
        add(32'h34011073, 64'h0, 0, 0, 64'h0, 0, 0);
`else
        add(32'h34015073, 64'h0, 0, 1, 64'h0, 0, 1);
        add(32'h34011073, 64'h0, 0, 1, 64'h0, 0, 1);
`endif
        st = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h0080006F};
        ops = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h73, 7'h00};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        for (int d = 0; d < 2; d++) begin
            chk("reset out_valid", 64'(ov[d]), 0);
            chk("reset imm", im[d], 0);
            chk("reset fmt", 64'(fm[d]), 0);
            chk("reset illegal", 64'(il[d]), 0);
            chk("reset tag", 64'(tg[d]), 0);
            chk("reset ill_cnt", 64'(ct[d]), 0);
            chk("reset in_ready", 64'(ir[d]), 1);
        end

        out_ready_i = 1; in_valid_i = 1; instr_i = 0;
        repeat (5) cyc;
        in_valid_i = 0;
        cyc;
        chk("sat x32 ill_cnt", 64'(cnt32), 3);
        chk("sat x64 ill_cnt", 64'(cnt64), 5);
        rst = 1;
        cyc;
        rst = 0;
        chk("rerst x32 ill_cnt", 64'(cnt32), 0);

        foreach (tbl[i]) begin
            in_valid_i = 1; instr_i = tbl[i].instr; tag_i = 32'h1000 + 32'(i * 4);
            cyc;
            in_valid_i = 0;
            chk("vec x32 valid", 64'(ov32), 1);
            chk("vec x32 imm", 64'(imm32), tbl[i].imm32);
            chk("vec x32 fmt", 64'(fmt32), 64'(tbl[i].f32));
            chk("vec x32 illegal", 64'(ill32), 64'(tbl[i].il32));
            chk("vec x32 tag", 64'(tag32), 64'(tag_i));
            chk("vec x64 imm", imm64, tbl[i].imm64);
            chk("vec x64 fmt", 64'(fmt64), 64'(tbl[i].f64));
            chk("vec x64 illegal", 64'(ill64), 64'(tbl[i].il64));
        end
        cyc;

        base = del_cnt; k = 0; out_ready_i = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready_i = c >= 3; in_valid_i = k < 4; instr_i = st[k[1:0]]; tag_i = 32'h2000 + 32'(k);
            @(negedge clk);
            a = in_valid_i && ir32;
            cyc;
            if (a) begin
                k++;
                if (k == 1) chk("stream ready_after_1st", 64'(ir32), 1);
                if (k == 2) chk("stream ready_after_2nd", 64'(ir32), 0);
            end
        end
        in_valid_i = 0;
        chk("stream accepted", 64'(k), 4);
        chk("stream delivered", 64'(del_cnt - base), 4);

        out_ready_i = 0; in_valid_i = 1; instr_i = 0; tag_i = 32'h3000;
        cyc;
        instr_i = 32'hFFF00093; tag_i = 32'h3001;
        cyc;
        chk("flush skid_full", 64'(ir32), 0);
        instr_i = 32'h800002B7; tag_i = 32'h3002; flush_i = 1;
        cyc;
        flush_i = 0; in_valid_i = 0;
        chk("flush x32 valid", 64'(ov32), 0);
        chk("flush x64 valid", 64'(ov64), 0);
        out_ready_i = 1;
        repeat (3) begin
            cyc;
            chk("flush no_accept", 64'(ov32 | ov64), 0);
        end

        out_ready_i = 0; in_valid_i = 1; instr_i = 32'hFE112E23;
        repeat (2) cyc;
        in_valid_i = 0; rst = 1;
        cyc;
        rst = 0; out_ready_i = 1;
        repeat (3) begin
            cyc;
            chk("rst_mid no_deliver", 64'(ov32 | ov64), 0);
        end

        for (int c = 0; c < 600; c++) begin
            logic [31:0] r;
            int sel;
            r = $urandom;
            sel = $urandom_range(0, 11);
            instr_i = {r[31:7], sel == 11 ? r[6:0] : ops[sel]};
            tag_i = $urandom;
            in_valid_i = $urandom_range(0, 3) != 0;
            out_ready_i = $urandom_range(0, 3) != 0;
            flush_i = $urandom_range(0, 40) == 0;
            if (flush_i) out_ready_i = 0;
            cyc;
        end
        flush_i = 0; in_valid_i = 0; out_ready_i = 1;
        repeat (4) cyc;
        chk("drain x32 empty", 64'(q[0].size()), 0);
        chk("drain x64 empty", 64'(q[1].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
